riscv_ifetch_buffer: RTL

RISCV_IFETCH_BUFFER -- requirements
Module: riscv_ifetch_buffer

---
 rtl/riscv_ifetch_buffer_if.sv | 29 ++
 rtl/riscv_ifetch_buffer.sv | 111 +++++++++++
 2 files changed

// File: rtl/riscv_ifetch_buffer_if.sv
// Fetch-buffer bus: instruction-memory request/response, pipeline redirect,
// and the instruction/PC hand-off to decode.
`timescale 1ns/1ps
interface riscv_ifetch_buffer_if #(
    parameter int RISCV_XLEN      = 32,
    parameter int RISCV_INSTR_LEN = 32
);
    logic                       imem_req;
    logic [RISCV_XLEN-1:0]      imem_addr;
    logic                       imem_gnt;
    logic                       imem_rvalid;
    logic [RISCV_INSTR_LEN-1:0] imem_rdata;
    logic                       redirect;
    logic [RISCV_XLEN-1:0]      redirect_pc;
    logic                       instr_valid;
    logic [RISCV_INSTR_LEN-1:0] instruction;
    logic [RISCV_XLEN-1:0]      PC;
    logic                       instr_ready;

    // master: the fetch buffer; slave: memory plus pipeline environment
    modport master (
        output imem_req, imem_addr, instr_valid, instruction, PC,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instruction, PC,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/riscv_ifetch_buffer.sv
// In-order instruction fetch buffer: issues word fetches, queues returned
// instructions with their PCs, and flushes/discards stale responses on redirect.
`timescale 1ns/1ps
module riscv_ifetch_buffer #(
    parameter int                    RISCV_XLEN      = 32,
    parameter int                    RISCV_INSTR_LEN = 32,
    parameter int                    DEPTH           = 4,
    parameter logic [RISCV_XLEN-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_ifetch_buffer_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef logic [RISCV_XLEN-1:0]      addr_t;
    typedef logic [RISCV_INSTR_LEN-1:0] instr_t;
    typedef logic [PTR_W-1:0]           ptr_t;
    typedef logic [CNT_W-1:0]           cnt_t;

    addr_t  fetch_pc_q, fetch_pc_d;
    addr_t  out_pc_q, out_pc_d;
    instr_t fifo_q [DEPTH];
    instr_t fifo_d [DEPTH];
    ptr_t   rd_ptr_q, rd_ptr_d;
    ptr_t   wr_ptr_q, wr_ptr_d;
    cnt_t   count_q, count_d;
    cnt_t   outst_q, outst_d;
    cnt_t   discard_q, discard_d;

    logic           req, grant, pop, push;
    logic [CNT_W:0] inflight;
    addr_t          redirect_aligned;
    logic           unused_rpc_lsb;

    assign redirect_aligned = {bus.redirect_pc[RISCV_XLEN-1:2], 2'b00};
    assign unused_rpc_lsb   = ^bus.redirect_pc[1:0];

    // Every outstanding request owns a FIFO slot, so pushes can never overflow.
    assign inflight = {1'b0, count_q} + {1'b0, outst_q};
    assign req      = ~rst & ~bus.redirect & (inflight < DEPTH_C);
    assign grant    = req & bus.imem_gnt;
    assign pop      = bus.instr_valid & bus.instr_ready & ~bus.redirect;
    assign push     = bus.imem_rvalid & ~bus.redirect & (discard_q == '0);

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = ~rst & (count_q != '0);
    assign bus.instruction = fifo_q[rd_ptr_q];
    assign bus.PC          = out_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_pc_d   = out_pc_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q + cnt_t'(grant) - cnt_t'(bus.imem_rvalid);

        if (bus.redirect) begin
            // Whatever is still in flight after this cycle belongs to the old stream.
            fetch_pc_d = redirect_aligned;
            out_pc_d   = redirect_aligned;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outst_q - cnt_t'(bus.imem_rvalid);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + addr_t'(4);
            if (pop) begin
                out_pc_d = out_pc_q + addr_t'(4);
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            if (push) begin
                fifo_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d         = wr_ptr_q + ptr_t'(1);
            end
            if (bus.imem_rvalid && discard_q != '0) discard_d = discard_q - cnt_t'(1);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_pc_q   <= out_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end
endmodule
